mv_to_adc_code: RTL and testbench
=================================

Name: mv_to_adc_code

Overview:
Inverse of the ADC millivolt scaling path. Converts a millivolt value, such as a threshold or setpoint from the UI/switch logic, into the equivalent averaged-ADC code so comparisons can be done in the raw code domain. The conversion is code = (mv << SHIFT_BITS) / SCALING_FACTOR, computed with a multi-cycle restoring divider behind valid/ready handshakes on input and output. Sits between the control/setpoint logic and the code-domain comparators.

Parameters:
SCALING_FACTOR, 106, divisor; must match the forward scaling constant; must be >0 and <2^16.
SHIFT_BITS, 13, left shift applied to mv before division; must match the forward shift.
CODE_WIDTH, 16, width of mv_in and adc_code.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
mv_in  input  CODE_WIDTH  millivolt value to convert
mv_valid  input  1  mv_in is valid
mv_ready  output  1  block can accept mv_in
adc_code  output  CODE_WIDTH  converted code, saturated
code_valid  output  1  adc_code/overflow are valid
code_ready  input  1  downstream accepts result
overflow  output  1  quotient exceeded 2^CODE_WIDTH-1; adc_code forced to all-ones
busy  output  1  high in DIVIDE or DONE

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE; mv_ready=1; code_valid=0; adc_code=0; overflow=0; busy=0; all internal dividend/remainder/quotient/count registers are cleared. Asserting reset mid-division aborts the operation, and no result is emitted.
- Outputs are all registered.
- DIV_BITS = CODE_WIDTH+SHIFT_BITS (29 by default).
  - Dividend = {mv_in, SHIFT_BITS zeros}, DIV_BITS wide.
  - Remainder register is $clog2(SCALING_FACTOR)+1 bits.
- IDLE:
  - mv_ready=1.
  - On mv_valid&&mv_ready: latch the dividend, clear remainder, quotient and count; go to DIVIDE; mv_ready=0.
- DIVIDE: one restoring step per clock, MSB first.
  - rem' = {rem, next dividend bit}.
  - If rem' >= SCALING_FACTOR: rem = rem' - SCALING_FACTOR and the quotient bit is 1; otherwise rem = rem' and the quotient bit is 0.
  - Exactly DIV_BITS steps. On the clock edge of the final step, adc_code, overflow and code_valid are loaded, and the state becomes DONE.
- Latency: code_valid rises exactly DIV_BITS clocks after the accept edge (29 by default). Throughput is one conversion per DIV_BITS+2 clocks minimum.
- Saturation:
  - If any quotient bit at or above CODE_WIDTH is set: adc_code = all-ones, overflow=1.
  - Otherwise: adc_code = quotient[CODE_WIDTH-1:0], overflow=0.
- Rounding: truncation (floor) by default.
- DONE:
  - code_valid=1; adc_code and overflow are held stable until the transfer.
  - On code_ready: code_valid=0, state becomes IDLE, and mv_ready=1 from the next cycle. There is no same-cycle accept of a new input.
  - code_ready may be held high indefinitely. code_ready while code_valid=0 is ignored.
- mv_valid while mv_ready=0 is ignored. The input is not buffered, and upstream must hold it.
- mv_in changes after the accept edge do not affect the result.

Optional Feature:
Macro MV_TO_ADC_ROUND_EN.
- Defined: dividend = (mv_in << SHIFT_BITS) + (SCALING_FACTOR >> 1), giving round-half-up to nearest. Width stays DIV_BITS for the defaults, since the maximum is 2^29-8192+53. Saturation is applied after rounding.
- Undefined: truncation as above. Latency is identical in both builds.

Test Plan:
1. Reset low mid-DIVIDE, after an accept of mv_in=500 and 10 clocks -> immediately code_valid=0, mv_ready=1, adc_code=0, overflow=0, busy=0. No result appears after reset release.
2. mv_in=100, code_ready=1 -> code_valid exactly 29 clocks after accept; adc_code=7728 (0x1E30), overflow=0 (both builds).
3. mv_in=500 -> adc_code=38641 with truncation; 38642 with MV_TO_ADC_ROUND_EN (remainder 54 >= 53).
4. Boundaries:
   - mv_in=847 -> adc_code=65458 truncated (65459 rounded), overflow=0.
   - mv_in=848 -> adc_code=0xFFFF, overflow=1.
   - mv_in=0 -> adc_code=0.
5. Backpressure: mv_in=100, code_ready=0 for 20 clocks after code_valid -> adc_code and code_valid stay stable, mv_ready=0, and a new mv_valid is ignored. After code_ready=1 for one clock: code_valid=0, and mv_ready=1 on the following cycle.
6. Back-to-back inputs 847 then 848 with mv_valid held high and code_ready=1 -> two results in order (65458/0 then 0xFFFF/1), each DIV_BITS clocks after its accept. mv_in changes after the accept edge do not alter the first result.

Source files
------------

// File: rtl/mv_to_adc_code.sv
// Millivolt-to-ADC-code converter: code = (mv << SHIFT_BITS) / SCALING_FACTOR using a restoring divider.
// Define MV_TO_ADC_ROUND_EN for round-half-up instead of truncation.
module mv_to_adc_code #(
    parameter int SCALING_FACTOR = 106,
    parameter int SHIFT_BITS     = 13,
    parameter int CODE_WIDTH     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CODE_WIDTH-1:0] mv_in,
    input  logic                  mv_valid,
    output logic                  mv_ready,
    output logic [CODE_WIDTH-1:0] adc_code,
    output logic                  code_valid,
    input  logic                  code_ready,
    output logic                  overflow,
    output logic                  busy
);

    localparam int DIV_BITS = CODE_WIDTH + SHIFT_BITS;
    localparam int REM_W    = $clog2(SCALING_FACTOR) + 1;
    localparam int CNT_W    = $clog2(DIV_BITS + 1);

    localparam logic [REM_W:0] DIVISOR = (REM_W + 1)'(SCALING_FACTOR);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DIVIDE = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]          state;
    logic [DIV_BITS-1:0] dividend;
    logic [DIV_BITS-2:0] quotient;
    logic [REM_W-1:0]    remainder;
    logic [CNT_W-1:0]    count;

    logic [REM_W:0]      trial;
    logic [REM_W-1:0]    diff;
    logic [REM_W-1:0]    rem_next;
    logic                q_bit;
    logic [DIV_BITS-1:0] quot_next;
    logic                quot_ovf;
    logic                last_step;
    logic [DIV_BITS-1:0] load_dividend;

`ifdef MV_TO_ADC_ROUND_EN
    assign load_dividend = {mv_in, {SHIFT_BITS{1'b0}}} + DIV_BITS'(SCALING_FACTOR >> 1);
`else
    assign load_dividend = {mv_in, {SHIFT_BITS{1'b0}}};
`endif

    // The remainder stays below the divisor, so a trial value never reaches 2^REM_W
    // and the subtraction can be done on the low REM_W bits.
    always_comb begin
        trial     = {remainder, dividend[DIV_BITS-1]};
        q_bit     = (trial >= DIVISOR);
        diff      = trial[REM_W-1:0] - DIVISOR[REM_W-1:0];
        rem_next  = q_bit ? diff : trial[REM_W-1:0];
        quot_next = {quotient, q_bit};
        quot_ovf  = |quot_next[DIV_BITS-1:CODE_WIDTH];
        last_step = (count == CNT_W'(DIV_BITS - 1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            dividend   <= '0;
            quotient   <= '0;
            remainder  <= '0;
            count      <= '0;
            mv_ready   <= 1'b1;
            adc_code   <= '0;
            code_valid <= 1'b0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mv_valid && mv_ready) begin
                        dividend  <= load_dividend;
                        remainder <= '0;
                        quotient  <= '0;
                        count     <= '0;
                        state     <= DIVIDE;
                        mv_ready  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                DIVIDE: begin
                    dividend  <= dividend << 1;
                    remainder <= rem_next;
                    quotient  <= quot_next[DIV_BITS-2:0];
                    count     <= count + 1'b1;
                    if (last_step) begin
                        state      <= DONE;
                        code_valid <= 1'b1;
                        overflow   <= quot_ovf;
                        adc_code   <= quot_ovf ? '1 : quot_next[CODE_WIDTH-1:0];
                    end
                end
                DONE: begin
                    // New input is only accepted from the cycle after the transfer.
                    if (code_ready) begin
                        code_valid <= 1'b0;
                        state      <= IDLE;
                        mv_ready   <= 1'b1;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    mv_ready   <= 1'b1;
                    code_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mv_to_adc_code.sv
// Directed testbench for mv_to_adc_code; expected codes are hand-computed for both rounding builds.
module tb_mv_to_adc_code;

    localparam int DIV_BITS = 29;

`ifdef MV_TO_ADC_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [15:0] mv_in;
    logic        mv_valid;
    logic        mv_ready;
    logic [15:0] adc_code;
    logic        code_valid;
    logic        code_ready;
    logic        overflow;
    logic        busy;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [15:0] mv;
        logic [15:0] code_trunc;
        logic [15:0] code_round;
        logic        ovf;
    } vec_t;

    vec_t vecs[5];

    mv_to_adc_code dut (
        .clk       (clk),
        .reset     (reset),
        .mv_in     (mv_in),
        .mv_valid  (mv_valid),
        .mv_ready  (mv_ready),
        .adc_code  (adc_code),
        .code_valid(code_valid),
        .code_ready(code_ready),
        .overflow  (overflow),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitReady();
        int n = 0;
        while (mv_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checkOutput("wait_mv_ready", {31'd0, mv_ready}, 32'd1);
    endtask

    // Counts clocks from the current sample point until code_valid, bounded.
    task automatic waitValid(output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (code_valid !== 1'b1 && cycles < 100);
    endtask

    // Single handshake with mv_valid dropped (and mv_in scrambled) right after the accept edge.
    task automatic applyStimulus(input logic [15:0] mv, output int latency);
        waitReady();
        mv_in    = mv;
        mv_valid = 1'b1;
        tick();
        mv_valid = 1'b0;
        mv_in    = 16'hAAAA;
        checkOutput("mv_ready_low_after_accept", {31'd0, mv_ready}, 32'd0);
        checkOutput("busy_after_accept", {31'd0, busy}, 32'd1);
        waitValid(latency);
    endtask

    initial begin
        int lat;
        logic [15:0] exp_code;

        vecs[0] = '{mv: 16'd100, code_trunc: 16'd7728,  code_round: 16'd7728,  ovf: 1'b0};
        vecs[1] = '{mv: 16'd500, code_trunc: 16'd38641, code_round: 16'd38642, ovf: 1'b0};
        vecs[2] = '{mv: 16'd847, code_trunc: 16'd65458, code_round: 16'd65459, ovf: 1'b0};
        vecs[3] = '{mv: 16'd848, code_trunc: 16'hFFFF,  code_round: 16'hFFFF,  ovf: 1'b1};
        vecs[4] = '{mv: 16'd0,   code_trunc: 16'd0,     code_round: 16'd0,     ovf: 1'b0};

        reset      = 1'b0;
        mv_in      = '0;
        mv_valid   = 1'b0;
        code_ready = 1'b1;
        #12;
        checkOutput("reset_mv_ready", {31'd0, mv_ready}, 32'd1);
        checkOutput("reset_code_valid", {31'd0, code_valid}, 32'd0);
        checkOutput("reset_adc_code", {16'd0, adc_code}, 32'd0);
        checkOutput("reset_overflow", {31'd0, overflow}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            exp_code = ROUND ? vecs[i].code_round : vecs[i].code_trunc;
            applyStimulus(vecs[i].mv, lat);
            checkOutput($sformatf("latency_mv%0d", vecs[i].mv), lat, DIV_BITS);
            checkOutput($sformatf("adc_code_mv%0d", vecs[i].mv), {16'd0, adc_code}, {16'd0, exp_code});
            checkOutput($sformatf("overflow_mv%0d", vecs[i].mv), {31'd0, overflow}, {31'd0, vecs[i].ovf});
            checkOutput($sformatf("busy_done_mv%0d", vecs[i].mv), {31'd0, busy}, 32'd1);
            tick();
            checkOutput($sformatf("valid_drop_mv%0d", vecs[i].mv), {31'd0, code_valid}, 32'd0);
            checkOutput($sformatf("ready_back_mv%0d", vecs[i].mv), {31'd0, mv_ready}, 32'd1);
        end

        // Leave a nonzero code behind so the reset check below is meaningful.
        applyStimulus(16'd100, lat);
        tick();
        applyStimulus(16'd500, lat);
        tick();
        waitReady();
        mv_in    = 16'd500;
        mv_valid = 1'b1;
        tick();
        mv_valid = 1'b0;
        repeat (10) tick();
        reset = 1'b0;
        #1;
        checkOutput("abort_code_valid", {31'd0, code_valid}, 32'd0);
        checkOutput("abort_mv_ready", {31'd0, mv_ready}, 32'd1);
        checkOutput("abort_adc_code", {16'd0, adc_code}, 32'd0);
        checkOutput("abort_overflow", {31'd0, overflow}, 32'd0);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        tick();
        reset = 1'b1;
        begin
            int seen = 0;
            for (int c = 0; c < 40; c++) begin
                tick();
                if (code_valid === 1'b1 || busy === 1'b1) seen++;
            end
            checkOutput("abort_no_result", seen, 0);
        end

        // Backpressure: result held for 20 clocks while a new request is ignored.
        code_ready = 1'b0;
        applyStimulus(16'd100, lat);
        checkOutput("bp_latency", lat, DIV_BITS);
        mv_in    = 16'd500;
        mv_valid = 1'b1;
        begin
            int bad = 0;
            for (int c = 0; c < 20; c++) begin
                tick();
                if (code_valid !== 1'b1 || adc_code !== 16'd7728 || mv_ready !== 1'b0 || overflow !== 1'b0)
                    bad++;
            end
            checkOutput("bp_hold_stable", bad, 0);
        end
        mv_valid   = 1'b0;
        code_ready = 1'b1;
        tick();
        checkOutput("bp_release_valid", {31'd0, code_valid}, 32'd0);
        checkOutput("bp_release_ready", {31'd0, mv_ready}, 32'd1);
        checkOutput("bp_release_busy", {31'd0, busy}, 32'd0);
        tick();
        checkOutput("bp_ignored_request", {31'd0, busy}, 32'd0);

        // Back-to-back with mv_valid held high.
        mv_in    = 16'd847;
        mv_valid = 1'b1;
        tick();
        mv_in = 16'd848;
        waitValid(lat);
        checkOutput("b2b_first_latency", lat, DIV_BITS);
        checkOutput("b2b_first_code", {16'd0, adc_code}, ROUND ? 32'd65459 : 32'd65458);
        checkOutput("b2b_first_ovf", {31'd0, overflow}, 32'd0);
        tick();
        checkOutput("b2b_gap_valid", {31'd0, code_valid}, 32'd0);
        checkOutput("b2b_gap_ready", {31'd0, mv_ready}, 32'd1);
        tick();
        mv_in    = 16'd0;
        mv_valid = 1'b0;
        checkOutput("b2b_second_accept", {31'd0, mv_ready}, 32'd0);
        waitValid(lat);
        checkOutput("b2b_second_latency", lat, DIV_BITS);
        checkOutput("b2b_second_code", {16'd0, adc_code}, 32'hFFFF);
        checkOutput("b2b_second_ovf", {31'd0, overflow}, 32'd1);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
